mic_array_xcorr: RTL and testbench

Multi-channel cross-correlation lag estimator for the acoustic camera microphone array. It generalises the two-microphone lag path to NUM_CH channels with configurable sample width, window depth and lag range. On a start request it captures a window of PCM samples from every channel. It then correlates each channel 1..NUM_CH-1 against channel 0 with one serial MAC and reports the peak lag per channel for the direction-finding logic downstream.

---
 rtl/mic_array_pkg.sv | 28 ++
 rtl/mic_array_xcorr_mac.sv | 85 ++++++++
 rtl/mic_array_xcorr.sv | 170 +++++++++++++++++
 tb/tb_mic_array_xcorr.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_array_pkg.sv
// Shared constants and elaboration helpers for the microphone-array cross-correlator.
package mic_array_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_CORR    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int DEF_LAGNUM = 10;
  localparam int DEF_LAG_W  = 6;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int idx_w(input int window);
    return clog2(window);
  endfunction

  // Sum of WINDOW full-scale products needs log2(WINDOW) guard bits.
  function automatic int acc_w(input int sample_w, input int window);
    return 2 * sample_w + clog2(window);
  endfunction

endpackage

// File: rtl/mic_array_xcorr_mac.sv
// Serial signed MAC with per-lag clear and strict-greater peak tracking per channel.
module xcorr_mac_peak
  import mic_array_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 38,
  parameter int LAG_W    = 6,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vld_p1,
  input  logic signed [SAMPLE_W-1:0] a_p1,
  input  logic signed [SAMPLE_W-1:0] b_p1,
  input  logic                       first_p1,
  input  logic                       last_p1,
  input  logic                       lag_first_p1,
  input  logic                       lag_last_p1,
  input  logic signed [LAG_W-1:0]    lag_p1,
  input  logic [CH_W-1:0]            ch_p1,
  output logic                       chan_done,
  output logic [CH_W-1:0]            chan_id,
  output logic signed [LAG_W-1:0]    best_lag
);

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*SAMPLE_W-1:0] p);
    return {{(ACC_W-2*SAMPLE_W){p[2*SAMPLE_W-1]}}, p};
  endfunction

  logic signed [2*SAMPLE_W-1:0] prod_p2;
  logic                         vld_p2, first_p2, last_p2, lag_first_p2, lag_last_p2;
  logic signed [LAG_W-1:0]      lag_p2;
  logic [CH_W-1:0]              ch_p2;
  logic signed [ACC_W-1:0]      acc, peak, acc_next;
  logic signed [LAG_W-1:0]      peak_lag;
  logic                         load_pk;

  // p1 -> p2: registered multiply
  always_ff @(posedge clk) begin
    prod_p2 <= a_p1 * b_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2       <= 1'b0;
      first_p2     <= 1'b0;
      last_p2      <= 1'b0;
      lag_first_p2 <= 1'b0;
      lag_last_p2  <= 1'b0;
      lag_p2       <= '0;
      ch_p2        <= '0;
    end else begin
      vld_p2       <= vld_p1;
      first_p2     <= first_p1;
      last_p2      <= last_p1;
      lag_first_p2 <= lag_first_p1;
      lag_last_p2  <= lag_last_p1;
      lag_p2       <= lag_p1;
      ch_p2        <= ch_p1;
    end
  end

  // p2: accumulate; the first lag of a channel always seeds the peak
  assign acc_next = (first_p2 ? '0 : acc) + sext_prod(prod_p2);
  assign load_pk  = last_p2 && (lag_first_p2 || (acc_next > peak));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      peak     <= '0;
      peak_lag <= '0;
    end else if (vld_p2) begin
      acc <= acc_next;
      if (load_pk) begin
        peak     <= acc_next;
        peak_lag <= lag_p2;
      end
    end
  end

  assign chan_done = vld_p2 && last_p2 && lag_last_p2;
  assign chan_id   = ch_p2;
  assign best_lag  = load_pk ? lag_p2 : peak_lag;

endmodule

// File: rtl/mic_array_xcorr.sv
// Multi-channel lag estimator: capture a window per channel, then correlate each channel against channel 0.
module mic_array_xcorr
  import mic_array_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int WINDOW   = 64,
  parameter int LAGNUM   = DEF_LAGNUM,
  parameter int LAG_W    = DEF_LAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic                         xcorr_start,
  output logic                         busy,
  output logic                         lag_valid,
  output logic [(NUM_CH-1)*LAG_W-1:0]  lag_diff
);

  localparam int IDX_W = idx_w(WINDOW);
  localparam int ACC_W = acc_w(SAMPLE_W, WINDOW);
  localparam int CH_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int SUM_W = ((IDX_W > LAG_W) ? IDX_W : LAG_W) + 2;
  localparam logic signed [LAG_W-1:0] LAG_MIN = LAG_W'(-LAGNUM);
  localparam logic signed [LAG_W-1:0] LAG_MAX = LAG_W'(LAGNUM);

  logic [1:0]              state;
  logic [IDX_W-1:0]        wr_idx, n_cnt;
  logic [CH_W-1:0]         ch_cnt;
  logic signed [LAG_W-1:0] lag_cnt;
  logic                    issue_en;

  logic signed [SAMPLE_W-1:0] sbuf [NUM_CH][WINDOW];

  logic signed [SUM_W-1:0] n_ext, l_ext, idx_p0;
  logic                    in_range_p0, n_last_p0, lag_last_p0, ch_last_p0, issue_p0;

  logic signed [SAMPLE_W-1:0] a_p1, b_p1;
  logic                       vld_p1, first_p1, last_p1, lag_first_p1, lag_last_p1;
  logic signed [LAG_W-1:0]    lag_p1;
  logic [CH_W-1:0]            ch_p1;

  logic                    chan_done;
  logic [CH_W-1:0]         chan_id;
  logic signed [LAG_W-1:0] best_lag;

  always_ff @(posedge clk) begin
    if (state == ST_CAPTURE && sample_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sbuf[c][wr_idx] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // p0: index generation; WINDOW is a power of two so range is a bit test
  assign n_ext       = {{(SUM_W-IDX_W){1'b0}}, n_cnt};
  assign l_ext       = {{(SUM_W-LAG_W){lag_cnt[LAG_W-1]}}, lag_cnt};
  assign idx_p0      = n_ext + l_ext;
  assign in_range_p0 = !idx_p0[SUM_W-1] && (idx_p0[SUM_W-2:IDX_W] == '0);
  assign n_last_p0   = (n_cnt == IDX_W'(WINDOW-1));
  assign lag_last_p0 = (lag_cnt == LAG_MAX);
  assign ch_last_p0  = (ch_cnt == CH_W'(NUM_CH-1));
  assign issue_p0    = (state == ST_CORR) && issue_en;

  // p0 -> p1: buffer read, out-of-window terms forced to zero
  always_ff @(posedge clk) begin
    a_p1 <= sbuf[0][n_cnt];
    b_p1 <= in_range_p0 ? sbuf[ch_cnt][idx_p0[IDX_W-1:0]] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_idx       <= '0;
      n_cnt        <= '0;
      ch_cnt       <= '0;
      lag_cnt      <= '0;
      issue_en     <= 1'b0;
      lag_diff     <= '0;
      vld_p1       <= 1'b0;
      first_p1     <= 1'b0;
      last_p1      <= 1'b0;
      lag_first_p1 <= 1'b0;
      lag_last_p1  <= 1'b0;
      lag_p1       <= '0;
      ch_p1        <= '0;
    end else begin
      vld_p1       <= issue_p0;
      first_p1     <= (n_cnt == '0);
      last_p1      <= n_last_p0;
      lag_first_p1 <= (lag_cnt == LAG_MIN);
      lag_last_p1  <= lag_last_p0;
      lag_p1       <= lag_cnt;
      ch_p1        <= ch_cnt;

      case (state)
        ST_IDLE: begin
          if (xcorr_start) begin
            state  <= ST_CAPTURE;
            wr_idx <= '0;
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == IDX_W'(WINDOW-1)) begin
              state    <= ST_CORR;
              issue_en <= 1'b1;
              n_cnt    <= '0;
              lag_cnt  <= LAG_MIN;
              ch_cnt   <= CH_W'(1);
            end
          end
        end
        ST_CORR: begin
          if (issue_en) begin
            if (n_last_p0) begin
              n_cnt <= '0;
              if (lag_last_p0) begin
                lag_cnt <= LAG_MIN;
                if (ch_last_p0) issue_en <= 1'b0;
                else            ch_cnt   <= ch_cnt + 1'b1;
              end else begin
                lag_cnt <= lag_cnt + 1'b1;
              end
            end else begin
              n_cnt <= n_cnt + 1'b1;
            end
          end
          if (chan_done && chan_id == CH_W'(NUM_CH-1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (chan_done) begin
        for (int c = 1; c < NUM_CH; c++) begin
          if (chan_id == CH_W'(c)) lag_diff[(c-1)*LAG_W +: LAG_W] <= best_lag;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign lag_valid = (state == ST_DONE);

  xcorr_mac_peak #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W),
    .LAG_W    (LAG_W),
    .CH_W     (CH_W)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .vld_p1       (vld_p1),
    .a_p1         (a_p1),
    .b_p1         (b_p1),
    .first_p1     (first_p1),
    .last_p1      (last_p1),
    .lag_first_p1 (lag_first_p1),
    .lag_last_p1  (lag_last_p1),
    .lag_p1       (lag_p1),
    .ch_p1        (ch_p1),
    .chan_done    (chan_done),
    .chan_id      (chan_id),
    .best_lag     (best_lag)
  );

endmodule

// File: tb/tb_mic_array_xcorr.sv
// Directed bench for mic_array_xcorr: known channel delays must come back as the reported lags.
module tb_mic_array_xcorr;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int WINDOW   = 64;
  localparam int LAGNUM   = 10;
  localparam int LAG_W    = 6;
  localparam int LD_W     = (NUM_CH-1)*LAG_W;
  localparam int CORR_CYCLES = (NUM_CH-1)*(2*LAGNUM+1)*WINDOW + 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sample_valid;
  logic [NUM_CH*SAMPLE_W-1:0] sample_data;
  logic                       xcorr_start;
  logic                       busy;
  logic                       lag_valid;
  logic [LD_W-1:0]            lag_diff;

  int vectors = 0;
  int miscompares = 0;

  logic signed [SAMPLE_W-1:0] sig [0:127];
  int dly [NUM_CH];

  always #5 clk = ~clk;

  mic_array_xcorr #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WINDOW(WINDOW), .LAGNUM(LAGNUM), .LAG_W(LAG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .xcorr_start  (xcorr_start),
    .busy         (busy),
    .lag_valid    (lag_valid),
    .lag_diff     (lag_diff)
  );

  function automatic logic [LD_W-1:0] pack3(input int l1, input int l2, input int l3);
    logic signed [LAG_W-1:0] a, b, c;
    a = LAG_W'(l1);
    b = LAG_W'(l2);
    c = LAG_W'(l3);
    return {c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_noise(input logic [31:0] seed);
    logic [31:0] x;
    x = seed;
    for (int i = 0; i < 128; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      sig[i] = x[23:8];
    end
  endtask

  task automatic set_dly(input int d1, input int d2, input int d3);
    dly[0] = 0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  // Channel c carries sig delayed by dly[c]; strobes past the window carry junk.
  task automatic send_strobes(input int count, input int max_gap);
    for (int s = 0; s < count; s++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (s < WINDOW) sample_data[c*SAMPLE_W +: SAMPLE_W] = sig[s - dly[c] + 32];
        else            sample_data[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
      end
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      if (max_gap > 0 && s < count-1) repeat ($urandom_range(1, max_gap)) tick();
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!lag_valid && cycles < 6000) begin
      tick();
      cycles++;
    end
    if (!lag_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: lag_valid=%0b after %0d cycles, required 1", lag_valid, cycles);
    end
  endtask

  task automatic run(input int strobes, input int max_gap, output int cycles);
    xcorr_start = 1'b1;
    tick();
    xcorr_start = 1'b0;
    send_strobes(strobes, max_gap);
    wait_done(cycles);
  endtask

  task automatic check_lags(input string name, input logic [LD_W-1:0] exp);
    vectors++;
    if (lag_diff !== exp) begin
      miscompares++;
      $display("FAIL %s: lag_diff=%b required %b", name, lag_diff, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    xcorr_start = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy); end
    vectors++;
    if (lag_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", lag_valid); end
    check_lags("reset_lag_diff", '0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identical();
    int cyc;
    gen_noise(32'h1234_5678);
    set_dly(0, 0, 0);
    run(WINDOW, 0, cyc);
    vectors++;
    if (cyc !== CORR_CYCLES) begin
      miscompares++;
      $display("FAIL identical_latency: got %0d cycles required %0d", cyc, CORR_CYCLES);
    end
    check_lags("identical_lags", pack3(0, 0, 0));
    tick();
  endtask

  task automatic test_delays();
    int cyc;
    gen_noise(32'hCAFE_0001);
    set_dly(3, -5, 10);
    run(WINDOW, 0, cyc);
    check_lags("delay_lags", pack3(3, -5, 10));
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL delay_busy_on_valid: got %b required 1", busy); end
    tick();
    vectors++;
    if (busy !== 1'b0 || lag_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL delay_busy_fall: busy=%b lag_valid=%b required 0 0", busy, lag_valid);
    end
  endtask

  task automatic test_zeros();
    int cyc;
    for (int i = 0; i < 128; i++) sig[i] = '0;
    set_dly(0, 0, 0);
    run(WINDOW, 0, cyc);
    check_lags("zero_lags", {3{6'b110110}});
    tick();
  endtask

  task automatic test_start_held();
    int cyc;
    gen_noise(32'h0BAD_F00D);
    set_dly(1, -1, 4);
    xcorr_start = 1'b1;
    tick();
    send_strobes(WINDOW, 0);
    wait_done(cyc);
    check_lags("held_lags", pack3(1, -1, 4));
    tick();
    vectors++;
    if (busy !== 1'b0 || lag_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL held_idle_gap: busy=%b lag_valid=%b required 0 0", busy, lag_valid);
    end
    tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL held_restart: busy=%b required 1", busy); end
    xcorr_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_gaps();
    int cyc;
    gen_noise(32'hCAFE_0001);
    set_dly(3, -5, 10);
    run(WINDOW, 7, cyc);
    check_lags("gap_lags", pack3(3, -5, 10));
    tick();
  endtask

  task automatic test_extra_strobes();
    int cyc;
    gen_noise(32'h5A5A_1357);
    set_dly(-2, 7, 1);
    run(WINDOW + 6, 0, cyc);
    check_lags("extra_strobe_lags", pack3(-2, 7, 1));
    tick();
  endtask

  task automatic test_reset_mid_corr();
    int cyc;
    int seen;
    xcorr_start = 1'b1;
    tick();
    xcorr_start = 1'b0;
    send_strobes(WINDOW, 0);
    repeat (1000) tick();
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b required 0", busy); end
    check_lags("midreset_lag_diff", '0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < CORR_CYCLES + 50; i++) begin
      tick();
      if (lag_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL midreset_quiet: %0d active cycles, required 0", seen); end
    gen_noise(32'h7777_2024);
    set_dly(6, -8, 2);
    run(WINDOW, 0, cyc);
    check_lags("midreset_fresh_lags", pack3(6, -8, 2));
    tick();
  endtask

  initial begin
    test_reset();
    test_identical();
    test_delays();
    test_zeros();
    test_start_held();
    test_gaps();
    test_extra_strobes();
    test_reset_mid_corr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
